// File: rtl/muldiv_pkg.sv
// Shared types and opcode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } muldiv_state_t;

    function automatic logic is_div(input muldiv_op_t op);
        return op[2];
    endfunction

    function automatic logic is_rem(input muldiv_op_t op);
        return (op == REM) || (op == REMU);
    endfunction

    function automatic logic is_signed_a(input muldiv_op_t op);
        return op inside {MUL, MULH, MULHSU, DIV, REM};
    endfunction

    function automatic logic is_signed_b(input muldiv_op_t op);
        return op inside {MUL, MULH, DIV, REM};
    endfunction

endpackage

// File: rtl/muldiv_special_case.sv
// Detects divide-by-zero and signed-overflow divides, which bypass iteration
// and return their RISC-V defined value directly.
module muldiv_special_case
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            hit,
    output logic [XLEN-1:0] value
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_op_t op_e;
    assign op_e = muldiv_op_t'(op);

    always_comb begin
        hit   = 1'b0;
        value = '0;
        if (is_div(op_e)) begin
            if (b == '0) begin
                hit   = 1'b1;
                value = is_rem(op_e) ? a : '1;
            end else if (is_signed_a(op_e) && (a == MIN_NEG) && (&b)) begin
                hit   = 1'b1;
                value = is_rem(op_e) ? '0 : a;
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on
// operand magnitudes, with sign correction applied in a single FINISH cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    muldiv_state_t   state_reg;
    muldiv_op_t      op_reg;
    logic            neg_res_reg;
    logic            neg_rem_reg;
    logic            spec_reg;
    logic [CNT_W-1:0] count_reg;
    logic [XLEN-1:0] acc_reg;
    logic [XLEN-1:0] lo_reg;
    logic [XLEN-1:0] opnd_reg;
    logic [XLEN-1:0] result_reg;
    logic            done_reg;
    logic            busy_reg;

    muldiv_op_t      op_in;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            spec_hit;
    logic [XLEN-1:0] spec_value;

    assign op_in = muldiv_op_t'(op);
    assign a_neg = is_signed_a(op_in) & a[XLEN-1];
    assign b_neg = is_signed_b(op_in) & b[XLEN-1];
    assign mag_a = a_neg ? -a : a;
    assign mag_b = b_neg ? -b : b;

    muldiv_special_case #(.XLEN(XLEN)) u_special (
        .op    (op),
        .a     (a),
        .b     (b),
        .hit   (spec_hit),
        .value (spec_value)
    );

    // Multiply step: acc holds the running high half, lo the unconsumed multiplier bits.
    logic [XLEN:0] mul_sum;
    assign mul_sum = {1'b0, acc_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);

    // Divide step: acc is the partial remainder, lo shifts dividend out / quotient in.
    logic [XLEN:0] div_shift;
    logic [XLEN:0] div_diff;
    logic          div_sub;
    assign div_shift = {acc_reg, lo_reg[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opnd_reg};
    assign div_sub   = ~div_diff[XLEN];

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   final_value;

    assign prod_fix = neg_res_reg ? -{acc_reg, lo_reg} : {acc_reg, lo_reg};
    assign quo_fix  = neg_res_reg ? -lo_reg : lo_reg;
    assign rem_fix  = neg_rem_reg ? -acc_reg : acc_reg;

    always_comb begin
        final_value = '0;
        if (spec_reg) begin
            final_value = lo_reg;
        end else begin
            case (op_reg)
                MUL:                  final_value = prod_fix[XLEN-1:0];
                MULH, MULHSU, MULHU:  final_value = prod_fix[2*XLEN-1:XLEN];
                DIV, DIVU:            final_value = quo_fix;
                REM, REMU:            final_value = rem_fix;
                default:              final_value = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            op_reg      <= MUL;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            spec_reg    <= 1'b0;
            count_reg   <= '0;
            acc_reg     <= '0;
            lo_reg      <= '0;
            opnd_reg    <= '0;
            result_reg  <= '0;
            done_reg    <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start && !flush) begin
                        op_reg      <= op_in;
                        neg_res_reg <= a_neg ^ b_neg;
                        neg_rem_reg <= a_neg;
                        count_reg   <= '0;
                        acc_reg     <= '0;
                        busy_reg    <= 1'b1;
                        spec_reg    <= spec_hit;
                        if (spec_hit) begin
                            lo_reg    <= spec_value;
                            state_reg <= FINISH;
                        end else begin
                            lo_reg    <= is_div(op_in) ? mag_a : mag_b;
                            opnd_reg  <= is_div(op_in) ? mag_b : mag_a;
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        if (is_div(op_reg)) begin
                            acc_reg <= div_sub ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
                            lo_reg  <= {lo_reg[XLEN-2:0], div_sub};
                        end else begin
                            acc_reg <= mul_sum[XLEN:1];
                            lo_reg  <= {mul_sum[0], lo_reg[XLEN-1:1]};
                        end
                        count_reg <= count_reg + 1'b1;
                        if (count_reg == CNT_W'(XLEN-1)) begin
                            state_reg <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    if (!flush) begin
                        result_reg <= final_value;
                        done_reg   <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, randomized ops
// against an arithmetic reference model, plus handshake, flush and reset checks.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          n_checks;
    int          n_fail;
    logic [31:0] last_result;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic is_special(input int op_i, input logic [31:0] x, input logic [31:0] y);
        if (op_i < 4) return 1'b0;
        if (y == 32'd0) return 1'b1;
        return ((op_i == 4) || (op_i == 6)) && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    endfunction

    // RV32M results from plain 64-bit / integer arithmetic.
    function automatic logic [31:0] model(input int op_i, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, uy;
        logic [63:0] p;
        logic [63:0] ux64, uy64;
        int          ix, iy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        uy = longint'({32'd0, y});
        ux64 = {32'd0, x};
        uy64 = {32'd0, y};
        ix = x;
        iy = y;
        p = '0;
        case (op_i)
            0: begin p = sx * sy; return p[31:0]; end
            1: begin p = sx * sy; return p[63:32]; end
            2: begin p = sx * uy; return p[63:32]; end
            3: begin p = ux64 * uy64; return p[63:32]; end
            4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                return 32'(ix / iy);
            end
            5: begin
                if (y == 0) return 32'hFFFF_FFFF;
                return x / y;
            end
            6: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ix % iy);
            end
            default: begin
                if (y == 0) return x;
                return x % y;
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(1, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge of the done cycle. If intrude>0 a
    // stray start with other operands is driven so that it is sampled at that edge.
    task automatic do_op(input int op_i, input logic [31:0] x, input logic [31:0] y, input int intrude);
        int          edges;
        int          exp_lat;
        logic [31:0] exp;
        exp     = model(op_i, x, y);
        exp_lat = is_special(op_i, x, y) ? 2 : 34;
        start = 1'b1;
        op    = op_i[2:0];
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        edges = 1;
        forever begin
            if (edges + 1 == intrude) begin
                start = 1'b1;
                op    = 3'($urandom_range(0, 7));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (edges == 1) check("busy_after_start", {31'd0, busy}, 32'd1);
            if (done || edges >= 100) break;
            @(posedge clk);
            edges++;
            #1;
        end
        start = 1'b0;
        check("latency", 32'(edges), 32'(exp_lat));
        check("result", result, exp);
        check("busy_in_done", {31'd0, busy}, 32'd0);
        $display("op=%0d a=0x%08h b=0x%08h -> result=0x%08h (exp 0x%08h) lat=%0d",
                 op_i, x, y, result, exp, edges);
        last_result = exp;
    endtask

    typedef struct {
        int          op_i;
        logic [31:0] x;
        logic [31:0] y;
    } vec_t;

    vec_t dir_vec [13] = '{
        '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{3, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{2, 32'hFFFF_FFFF, 32'd2},
        '{4, 32'hFFFF_FFF9, 32'd2},
        '{6, 32'hFFFF_FFF9, 32'd2},
        '{5, 32'd100, 32'd7},
        '{7, 32'd100, 32'd7},
        '{5, 32'd100, 32'd0},
        '{7, 32'd100, 32'd0},
        '{4, 32'h8000_0000, 32'hFFFF_FFFF},
        '{6, 32'h8000_0000, 32'hFFFF_FFFF},
        '{2, 32'h8000_0000, 32'hFFFF_FFFF}
    };

    initial begin
        int          seen;
        logic [31:0] x;
        logic [31:0] y;
        n_checks    = 0;
        n_fail      = 0;
        last_result = '0;
        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'd0;
        a     = '0;
        b     = '0;

        @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        do_op(0, 32'd3006, 32'd3005, 0);
        check("mul_plan_value", result, 32'd9033030);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);

        // Directed cases run back-to-back: each start lands in the previous done cycle.
        foreach (dir_vec[i]) do_op(dir_vec[i].op_i, dir_vec[i].x, dir_vec[i].y, 0);

        // Stray start while busy must not disturb the running MUL.
        @(negedge clk);
        do_op(0, 32'd12345, 32'hFFFF_FFFD, 5);
        do_op(5, 32'd99, 32'd10, 6);

        for (int i = 0; i < 60; i++) begin
            x = pick_operand();
            y = pick_operand();
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op(int'($urandom_range(0, 7)), x, y, 0);
        end

        // Flush at cycle 10 of a DIV.
        @(negedge clk);
        start = 1'b1;
        op    = 3'd4;
        a     = 32'hDEAD_BEEF;
        b     = 32'd13;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("flush_no_done", 32'(seen), 32'd0);
        check("flush_result_kept", result, last_result);

        // flush and start together in IDLE: start is dropped.
        start = 1'b1;
        flush = 1'b1;
        op    = 3'd0;
        a     = 32'd5;
        b     = 32'd6;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_idle", {31'd0, busy}, 32'd0);
        @(negedge clk);

        // Flush alone in IDLE is harmless; a following op still works.
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        do_op(6, 32'hFFFF_FF9C, 32'd7, 0);

        // Async reset mid-CALC clears outputs without a clock edge.
        @(negedge clk);
        start = 1'b1;
        op    = 3'd0;
        a     = 32'd77;
        b     = 32'd88;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("busy_before_reset", {31'd0, busy}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_busy", {31'd0, busy}, 32'd0);
        check("async_reset_done", {31'd0, done}, 32'd0);
        check("async_reset_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_op(1, 32'h1234_5678, 32'h9ABC_DEF0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
